// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write arbiter slice.
//   arb_state_e : arbiter FSM states (idle arbitration / locked burst)
//   idx_w       : index width for an n-entry vector (never below 1 bit)
//   wrap_idx    : (base + off) modulo n for base < n and off <= n
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : $clog2(n);
    endfunction

    // Single conditional subtract is enough because base + off < 2n.
    function automatic int wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority encoder.
//   req_i    : request vector
//   rr_ptr_i : last-served index; search starts at rr_ptr_i+1 (mod N)
//   winner_o : index of the first set request found
//   found_o  : at least one request is set
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned N = 4,
    localparam int unsigned W = idx_w(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] rr_ptr_i,
    output logic [W-1:0] winner_o,
    output logic         found_o
);

    // Walk distances from farthest to nearest so the nearest request wins.
    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        for (int i = int'(N); i >= 1; i--) begin
            for (int k = 0; k < int'(N); k++) begin
                if (req_i[k] && (k == wrap_idx(int'(rr_ptr_i), i, int'(N)))) begin
                    winner_o = W'(k);
                    found_o  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ valid/ready producers, with burst locking capped at MAX_BURST beats.
//   i_clk, i_rstn  : clock, asynchronous active-low reset
//   i_req_valid    : per-requester beat valid
//   i_req_last     : per-requester final-beat marker
//   i_req_data     : packed data, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_req_ready    : one-hot-or-zero accept (combinational)
//   i_fifo_full    : FIFO full flag
//   o_fifo_write   : FIFO write strobe (combinational)
//   o_fifo_data    : grant holder's data, zero without a grant (combinational)
//   o_grant_id     : current winner / burst owner, zero without a grant
//   o_busy         : registered burst-lock flag
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned MAX_BURST  = 4,
    localparam int unsigned IDX_W      = idx_w(NUM_REQ),
    localparam int unsigned CNT_W      = idx_w(MAX_BURST + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ-1:0]            i_req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic                          i_fifo_full,
    output logic                          o_fifo_write,
    output logic [DATA_WIDTH-1:0]         o_fifo_data,
    output logic [IDX_W-1:0]              o_grant_id,
    output logic                          o_busy
);

    arb_state_e        state_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  owner_q;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic              busy_q;

    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_found;
    logic                  grant_valid;
    logic [IDX_W-1:0]      grant;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  xfer;
    logic                  last_eff;
    logic                  burst_end;

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req_i    (i_req_valid),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (pick_idx),
        .found_o  (pick_found)
    );

    // Grant selection; gated by reset so outputs go quiet the moment reset asserts.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        if (state_q == ARB_BURST) begin
            grant_valid = 1'b1;
            grant       = owner_q;
        end else if (pick_found) begin
            grant_valid = 1'b1;
            grant       = pick_idx;
        end
        if (!i_rstn) begin
            grant_valid = 1'b0;
            grant       = '0;
        end
    end

    // Grant-holder mux and per-requester ready.
    always_comb begin
        sel_valid   = 1'b0;
        sel_last    = 1'b0;
        sel_data    = '0;
        o_req_ready = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (grant_valid && (grant == IDX_W'(k))) begin
                sel_valid      = i_req_valid[k];
                sel_last       = i_req_last[k];
                sel_data       = i_req_data[k*int'(DATA_WIDTH) +: DATA_WIDTH];
                o_req_ready[k] = !i_fifo_full;
            end
        end
    end

    assign xfer      = grant_valid && !i_fifo_full && sel_valid;
    assign last_eff  = sel_last || (MAX_BURST == 32'd1);
    assign burst_end = last_eff || ((beat_cnt_q + CNT_W'(1)) == CNT_W'(MAX_BURST));

    assign o_fifo_write = xfer;
    assign o_fifo_data  = sel_data;
    assign o_grant_id   = grant;
    assign o_busy       = busy_q;

    // Arbiter FSM: state, pointer, owner and beat counter move only on a transfer.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
            owner_q    <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else if (xfer) begin
            case (state_q)
                ARB_IDLE: begin
                    if (last_eff) begin
                        rr_ptr_q <= grant;
                    end else begin
                        owner_q    <= grant;
                        beat_cnt_q <= CNT_W'(1);
                        state_q    <= ARB_BURST;
                        busy_q     <= 1'b1;
                    end
                end
                ARB_BURST: begin
                    if (burst_end) begin
                        rr_ptr_q   <= owner_q;
                        beat_cnt_q <= '0;
                        state_q    <= ARB_IDLE;
                        busy_q     <= 1'b0;
                    end else begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus random traffic, checked every
// cycle against a behavioural round-robin/burst model.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int IW = 2;

    logic              clk   = 1'b0;
    logic              rstn  = 1'b0;
    logic [NR-1:0]     valid = '0;
    logic [NR-1:0]     last  = '0;
    logic [NR*DW-1:0]  data  = '0;
    logic              full  = 1'b0;
    logic [NR-1:0]     ready;
    logic              fwrite;
    logic [DW-1:0]     fdata;
    logic [IW-1:0]     gid;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: last-served index, lock owner (-1 when none), beats taken in lock.
    int m_rr;
    int m_owner;
    int m_cnt;

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_req_valid  (valid),
        .i_req_last   (last),
        .i_req_data   (data),
        .o_req_ready  (ready),
        .i_fifo_full  (full),
        .o_fifo_write (fwrite),
        .o_fifo_data  (fdata),
        .o_grant_id   (gid),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle model comparison on the falling edge.
    always @(negedge clk) begin : compare
        int            g;
        bit            gv;
        logic [NR-1:0] er;
        logic          ew;
        logic [DW-1:0] ed;
        logic          eb;
        int            beats;
        if (!rstn) begin
            m_rr    = NR - 1;
            m_owner = -1;
            m_cnt   = 0;
        end
        gv = 0;
        g  = 0;
        if (rstn) begin
            if (m_owner >= 0) begin
                gv = 1;
                g  = m_owner;
            end else begin
                for (int i = NR; i >= 1; i--) begin
                    if (valid[(m_rr + i) % NR]) begin
                        gv = 1;
                        g  = (m_rr + i) % NR;
                    end
                end
            end
        end
        er = (gv && !full) ? (4'(1) << g) : '0;
        ew = gv && !full && valid[g];
        ed = gv ? data[g*DW +: DW] : '0;
        eb = (m_owner >= 0);
        chk("ready", 64'(ready), 64'(er));
        chk("write", 64'(fwrite), 64'(ew));
        chk("data", 64'(fdata), 64'(ed));
        chk("grant_id", 64'(gid), 64'(g));
        chk("busy", 64'(busy), 64'(eb));
        if (rstn && ew) begin
            beats = (m_owner < 0) ? 1 : m_cnt + 1;
            if (last[g] || beats == MB) begin
                m_rr    = g;
                m_owner = -1;
                m_cnt   = 0;
            end else begin
                m_owner = g;
                m_cnt   = beats;
            end
        end
    end

    task automatic rand_data();
        for (int k = 0; k < NR; k++) data[k*DW +: DW] = $urandom;
    endtask

    // One cycle of stimulus from posedge+1; optional literal check of id/busy/write.
    task automatic cyc(input logic [NR-1:0] v, input logic [NR-1:0] l, input logic f,
                       input int eid, input int ebusy, input int ewr, input string nm);
        valid = v;
        last  = l;
        full  = f;
        rand_data();
        @(negedge clk);
        #1;
        if (eid >= 0) begin
            chk({nm, "_id"}, 64'(gid), 64'(eid));
            chk({nm, "_busy"}, 64'(busy), 64'(ebusy));
            chk({nm, "_write"}, 64'(fwrite), 64'(ewr));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        valid = 4'b1111;
        last  = 4'b1111;
        rand_data();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'(0));
        chk("rst_write", 64'(fwrite), 64'(0));
        chk("rst_data", 64'(fdata), 64'(0));
        chk("rst_id", 64'(gid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rstn = 1'b1;

        // All requesters valid, single beats: strict rotation.
        cyc(4'b1111, 4'b1111, 1'b0, 0, 0, 1, "rot0");
        cyc(4'b1111, 4'b1111, 1'b0, 1, 0, 1, "rot1");
        cyc(4'b1111, 4'b1111, 1'b0, 2, 0, 1, "rot2");
        cyc(4'b1111, 4'b1111, 1'b0, 3, 0, 1, "rot3");
        cyc(4'b1111, 4'b1111, 1'b0, 0, 0, 1, "rot4");

        // Req 2 three-beat burst while req 1 waits.
        cyc(4'b0010, 4'b0010, 1'b0, 1, 0, 1, "pre1");
        cyc(4'b0110, 4'b0010, 1'b0, 2, 0, 1, "b2_1");
        cyc(4'b0110, 4'b0010, 1'b0, 2, 1, 1, "b2_2");
        cyc(4'b0110, 4'b0110, 1'b0, 2, 1, 1, "b2_3");
        cyc(4'b0110, 4'b0110, 1'b0, 1, 0, 1, "after_b2");

        // Req 0 never sets last: forced release after MAX_BURST beats.
        cyc(4'b1000, 4'b1000, 1'b0, 3, 0, 1, "pre3");
        cyc(4'b1001, 4'b1000, 1'b0, 0, 0, 1, "cap1");
        cyc(4'b1001, 4'b1000, 1'b0, 0, 1, 1, "cap2");
        cyc(4'b1001, 4'b1000, 1'b0, 0, 1, 1, "cap3");
        cyc(4'b1001, 4'b1000, 1'b0, 0, 1, 1, "cap4");
        cyc(4'b1001, 4'b1000, 1'b0, 3, 0, 1, "cap_r3");
        cyc(4'b1001, 4'b1000, 1'b0, 0, 0, 1, "cap5");
        cyc(4'b1001, 4'b1000, 1'b0, 0, 1, 1, "cap6");

        // FIFO full mid-burst: stall on the same owner.
        cyc(4'b1001, 4'b1000, 1'b1, 0, 1, 0, "full1");
        cyc(4'b1001, 4'b1000, 1'b1, 0, 1, 0, "full2");
        cyc(4'b1001, 4'b1000, 1'b1, 0, 1, 0, "full3");
        cyc(4'b1001, 4'b1000, 1'b0, 0, 1, 1, "full_res");

        // Owner drops valid: lock holds, nothing written.
        cyc(4'b1110, 4'b1110, 1'b0, 0, 1, 0, "drop1");
        cyc(4'b1110, 4'b1110, 1'b0, 0, 1, 0, "drop2");
        cyc(4'b0001, 4'b0001, 1'b0, 0, 1, 1, "drop_end");

        // Asynchronous reset in the middle of a burst.
        cyc(4'b0001, 4'b0000, 1'b0, 0, 0, 1, "rb1");
        cyc(4'b1111, 4'b0000, 1'b0, 0, 1, 1, "rb2");
        valid = 4'b1111;
        last  = 4'b0000;
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_ready", 64'(ready), 64'(0));
        chk("arst_write", 64'(fwrite), 64'(0));
        chk("arst_data", 64'(fdata), 64'(0));
        chk("arst_id", 64'(gid), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc(4'b1111, 4'b1111, 1'b0, 0, 0, 1, "post_rst");

        // Random traffic.
        repeat (3000) begin
            valid = NR'($urandom);
            last  = NR'($urandom) & NR'($urandom);
            full  = ($urandom_range(3) == 0);
            rand_data();
            @(posedge clk);
            #1;
        end

        valid = '0;
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
